// File: rtl/mlp_input_sequencer_if.sv
// mlp_input_sequencer_if: control/handshake bundle between the layer sequencer and the MAC side
interface mlp_input_sequencer_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 4
) ();
  logic             start;
  logic             abort;
  logic             ready_in;
  logic [SEL_W-1:0] sel;
  logic             valid_out;
  logic             first;
  logic             last;
  logic [CNT_W-1:0] neuron_idx;
  logic             busy;
  logic             done;
  modport master (
    input  start, abort, ready_in,
    output sel, valid_out, first, last, neuron_idx, busy, done
  );
  modport slave (
    output start, abort, ready_in,
    input  sel, valid_out, first, last, neuron_idx, busy, done
  );
endinterface

// File: rtl/mlp_input_sequencer.sv
// mlp_input_sequencer: steps the shared input-mux select through every input of every neuron in a layer
module mlp_input_sequencer #(
  parameter int N_IN      = 6,
  parameter int N_NEURONS = 10,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 4
) (
  input logic                   clk,
  input logic                   rst,
  mlp_input_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);
  localparam logic [SEL_W-1:0] PRE_LAST = SEL_W'(N_IN - 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_NEURONS - 1);
  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] idx;
  logic             valid, first, last, busy, done;
  assign bus.sel        = sel;
  assign bus.neuron_idx = idx;
  assign bus.valid_out  = valid;
  assign bus.first      = first;
  assign bus.last       = last;
  assign bus.busy       = busy;
  assign bus.done       = done;
  // Layer FSM; every output is registered so nothing combinational reaches the MAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      idx   <= '0;
      valid <= 1'b0;
      first <= 1'b0;
      last  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          state <= RUN;
          sel   <= '0;
          idx   <= '0;
          valid <= 1'b1;
          first <= 1'b1;
          last  <= (N_IN == 1);
          busy  <= 1'b1;
        end
        RUN: if (bus.abort) begin
          state <= IDLE;
          sel   <= '0;
          idx   <= '0;
          valid <= 1'b0;
          first <= 1'b0;
          last  <= 1'b0;
          busy  <= 1'b0;
        end else if (bus.ready_in) begin
          if (sel != LAST_SEL) begin
            sel   <= sel + SEL_W'(1);
            first <= 1'b0;
            last  <= (sel == PRE_LAST);
          end else if (idx != LAST_IDX) begin
            sel   <= '0;
            idx   <= idx + CNT_W'(1);
            first <= 1'b1;
            last  <= (N_IN == 1);
          end else begin
            state <= DONE;
            valid <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          idx   <= '0;
          valid <= 1'b0;
          first <= 1'b0;
          last  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_input_sequencer.sv
// tb_mlp_input_sequencer: directed checks of the layer input sequencer
module tb_mlp_input_sequencer;
  logic clk, rst;
  int total, bad;
  mlp_input_sequencer_if #(.SEL_W(3), .CNT_W(4)) b ();
  mlp_input_sequencer_if #(.SEL_W(3), .CNT_W(4)) s ();
  mlp_input_sequencer #(.N_IN(6), .N_NEURONS(3), .SEL_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mlp_input_sequencer #(.N_IN(1), .N_NEURONS(1), .SEL_W(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(s)
  );
  logic [11:0] obs, obs1;
  assign obs  = {b.valid_out, b.sel, b.neuron_idx, b.first, b.last, b.busy, b.done};
  assign obs1 = {s.valid_out, s.sel, s.neuron_idx, s.first, s.last, s.busy, s.done};
  localparam logic [11:0] M_CTRL = 12'b1_000_0000_1111;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    b.start = 0; b.abort = 0; b.ready_in = 0;
    s.start = 0; s.abort = 0; s.ready_in = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs !== 12'h000 || obs1 !== 12'h000) begin
      bad++;
      $display("FAIL reset: got %h/%h want 000/000", obs, obs1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [11:0] exp, m;
    int k;
    b.ready_in = 1'b1;
    @(negedge clk);
    b.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      b.start = 1'b0;
      k = (c - 1) % 6;
      m = (c == 19) ? M_CTRL : 12'hfff;
      if (c <= 18) exp = {1'b1, 3'(k), 4'((c - 1) / 6), k == 0, k == 5, 1'b1, 1'b0};
      else if (c == 19) exp = 12'b0_000_0000_0011;
      else exp = 12'h000;
      total++;
      if ((obs & m) !== exp) begin
        bad++;
        $display("FAIL basic cycle %0d: got %h want %h", c, obs & m, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, hs;
    bit seen;
    hs = 0;
    seen = 0;
    b.ready_in = 1'b1;
    @(negedge clk);
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    n = 0;
    while (b.sel != 3'd3 && n < 20) begin
      if (b.valid_out && b.ready_in) hs++;
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL bp_reach_sel3: timeout waiting for sel=3");
    end
    b.ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({b.valid_out, b.sel, b.first, b.last} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold %0d: got v/sel/f/l=%b/%0d/%b/%b want 1/3/0/0", i, b.valid_out, b.sel, b.first, b.last);
      end
    end
    b.ready_in = 1'b1;
    if (b.valid_out && b.ready_in) hs++;
    @(negedge clk);
    total++;
    if (b.sel !== 3'd4) begin
      bad++;
      $display("FAIL bp_resume: got sel=%0d want 4", b.sel);
    end
    n = 0;
    while (!b.done && n < 40) begin
      if (b.valid_out && b.ready_in) hs++;
      @(negedge clk);
      n++;
    end
    seen = b.done;
    total++;
    if (!seen || hs != 18) begin
      bad++;
      $display("FAIL bp_count: got handshakes=%0d done=%b want 18 done=1", hs, seen);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    bit sd;
    sd = 0;
    b.ready_in = 1'b1;
    @(negedge clk);
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    n = 0;
    while (!(b.sel == 3'd2 && b.neuron_idx == 4'd1) && n < 30) begin
      if (b.done) sd = 1;
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL abort_reach: timeout waiting for idx=1 sel=2");
    end
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL abort_idle: got %h want 000", obs);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b.done || b.busy || b.valid_out) sd = 1;
    end
    total++;
    if (sd) begin
      bad++;
      $display("FAIL abort_no_done: got activity/done=1 want none");
    end
  endtask

  task automatic test_restart();
    logic [11:0] exp, m;
    int k;
    b.ready_in = 1'b1;
    @(negedge clk);
    b.start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      b.start = 1'b0;
      k = (c - 1) % 6;
      m = (c == 19) ? M_CTRL : 12'hfff;
      if (c <= 18) exp = {1'b1, 3'(k), 4'((c - 1) / 6), k == 0, k == 5, 1'b1, 1'b0};
      else if (c == 19) exp = 12'b0_000_0000_0011;
      else if (c == 20) exp = 12'h000;
      else exp = 12'b1_000_0000_1010;
      total++;
      if ((obs & m) !== exp) begin
        bad++;
        $display("FAIL restart cycle %0d: got %h want %h", c, obs & m, exp);
      end
      b.start = (c == 5 || c == 19 || c == 20);
    end
    b.start = 1'b0;
    b.abort = 1'b1;
    @(negedge clk);
    b.abort = 1'b0;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL restart_abort: got %h want 000", obs);
    end
  endtask

  task automatic test_start_abort_idle();
    b.start = 1'b1;
    b.abort = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    b.abort = 1'b0;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL start_abort_idle: got %h want 000", obs);
    end
    @(negedge clk);
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL start_abort_idle2: got %h want 000", obs);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    b.ready_in = 1'b1;
    @(negedge clk);
    b.start = 1'b1;
    @(negedge clk);
    b.start = 1'b0;
    n = 0;
    while (!(b.sel == 3'd5 && b.neuron_idx == 4'd2) && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 30) begin
      bad++;
      $display("FAIL rst_reach: timeout waiting for idx=2 sel=5");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL rst_async: got %h want 000", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL rst_quiet %0d: got %h want 000", i, obs);
      end
    end
  endtask

  task automatic test_single();
    s.ready_in = 1'b1;
    @(negedge clk);
    s.start = 1'b1;
    @(negedge clk);
    s.start = 1'b0;
    total++;
    if (obs1 !== 12'b1_000_0000_1110) begin
      bad++;
      $display("FAIL single_elem: got %h want %h", obs1, 12'b1_000_0000_1110);
    end
    @(negedge clk);
    total++;
    if ((obs1 & M_CTRL) !== 12'b0_000_0000_0011) begin
      bad++;
      $display("FAIL single_done: got %h want %h", obs1 & M_CTRL, 12'b0_000_0000_0011);
    end
    @(negedge clk);
    total++;
    if (obs1 !== 12'h000) begin
      bad++;
      $display("FAIL single_idle: got %h want 000", obs1);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_restart();
    test_start_abort_idle();
    test_rst_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
